// File: rtl/tile_vram_arbiter.sv
// Shares the single-port tile-map RAM between VGA tile fetches (always win) and a host req/ack port.
// Define TILE_VRAM_VBLANK_LOCK_EN to restrict host access to vertical blanking (lines 480..523).
module tile_vram_arbiter #(
   parameter int unsigned DW   = 4,
   parameter int unsigned AW   = 11,
   parameter int unsigned COLS = 40,
   parameter int unsigned ROWS = 30
) (
   input  logic          CLOCK_50,
   input  logic [3:0]    KEY,
   input  logic          p_tick,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic [DW-1:0] tile_code
);

   typedef enum logic [1:0] {StIdle, StVid, StHwr, StHrd} bus_e;

   logic          rst;
   logic          unused_key;
   bus_e          state_q;
   logic          oor_q;
   logic          rd_pend_q;
   logic          rd_ok_q;
   logic          vid_pend_q;
   logic [DW-1:0] next_tile;
   logic [9:0]    next_line;
   logic          slot_col;
   logic          slot_line;
   logic          slot;
   logic [5:0]    row;
   logic [5:0]    col;
   logic [AW-1:0] vid_addr;
   logic          host_gate;
   logic          busy;
   logic          host_go;
   logic          in_range;
   logic          load_tile;

   assign rst        = KEY[0];
   assign unused_key = ^KEY[3:1];

   always_comb begin
      next_line = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
      slot_col  = p_tick && (pixel_x[3:0] == 4'd13) && (pixel_x <= 10'd621) && (pixel_y < 10'd480);
      slot_line = p_tick && (pixel_x == 10'd797) && (next_line < 10'd480);
      slot      = slot_col || slot_line;
      // Column 0 of the coming line is prefetched during horizontal blanking.
      row       = slot_line ? next_line[9:4] : pixel_y[9:4];
      col       = slot_line ? 6'd0 : pixel_x[9:4] + 6'd1;
      vid_addr  = AW'(32'(row) * COLS + 32'(col));
      load_tile = p_tick && ((pixel_x[3:0] == 4'hF) || (pixel_x == 10'd799));
   end

`ifdef TILE_VRAM_VBLANK_LOCK_EN
   assign host_gate = (pixel_y >= 10'd480) && (pixel_y <= 10'd523);
`else
   assign host_gate = 1'b1;
`endif

   // A host op stays in flight from its decision cycle through its ack cycle.
   assign busy       = (state_q == StHwr) || (state_q == StHrd) || rd_pend_q;
   assign host_go    = host_req && !busy && host_gate && !slot;
   assign in_range   = 32'(host_addr) < COLS * ROWS;
   assign host_rdata = rd_ok_q ? ram_rdata : '0;

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         oor_q      <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_ok_q    <= 1'b0;
         vid_pend_q <= 1'b0;
         next_tile  <= '0;
         tile_code  <= '0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= '0;
         host_ack   <= 1'b0;
      end else begin
         rd_pend_q  <= (state_q == StHrd);
         rd_ok_q    <= (state_q == StHrd) && !oor_q;
         vid_pend_q <= (state_q == StVid);
         host_ack   <= (host_go && host_we) || (state_q == StHrd);
         if (vid_pend_q) begin
            next_tile <= ram_rdata;
         end
         if (load_tile) begin
            tile_code <= next_tile;
         end
         ram_we <= 1'b0;
         oor_q  <= 1'b0;
         if (slot) begin
            state_q  <= StVid;
            ram_addr <= vid_addr;
         end else if (host_go) begin
            state_q <= host_we ? StHwr : StHrd;
            oor_q   <= !in_range;
            if (in_range) begin
               ram_addr <= host_addr;
               ram_we   <= host_we;
               if (host_we) begin
                  ram_wdata <= host_wdata;
               end
            end
         end else begin
            state_q <= StIdle;
         end
      end
   end

endmodule

// File: tb/tb_tile_vram_arbiter.sv
// Bench for tile_vram_arbiter: drives scan counters, models the RAM, and checks every cycle
// against a tile-map reference built from the scheduling rules.
module tb_tile_vram_arbiter;
   localparam int DW   = 4;
   localparam int AW   = 11;
   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int NT   = COLS * ROWS;
`ifdef TILE_VRAM_VBLANK_LOCK_EN
   localparam int HY = 500;
`else
   localparam int HY = 200;
`endif

   logic          CLOCK_50 = 1'b0;
   logic [3:0]    KEY;
   logic          p_tick;
   logic [9:0]    pixel_x;
   logic [9:0]    pixel_y;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic [DW-1:0] tile_code;

   tile_vram_arbiter dut (
      .CLOCK_50  (CLOCK_50),
      .KEY       (KEY),
      .p_tick    (p_tick),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .host_req  (host_req),
      .host_we   (host_we),
      .host_addr (host_addr),
      .host_wdata(host_wdata),
      .host_ack  (host_ack),
      .host_rdata(host_rdata),
      .tile_code (tile_code)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Synchronous RAM; unwritten words read back as (address mod 16).
   logic [DW-1:0] vram    [0:2047];
   bit            written [0:2047];
   always @(posedge CLOCK_50) begin
      if (ram_we) begin
         vram[ram_addr]    <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
      ram_rdata <= written[ram_addr] ? vram[ram_addr] : ram_addr[3:0];
   end

   logic [DW-1:0] ref_mem [0:NT-1];
   int            n_tests;
   int            n_fail;
   int            cyc_n;
   bit            tile_chk;
   logic [AW-1:0] exp_addr;
   bit            h_pend;
   bit            h_acc;
   bit            h_done;
   int            h_acc_cyc;
   bit            h_we_m;
   int            h_addr_m;
   logic [DW-1:0] h_data_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d x=%0d y=%0d)",
                tag, got, exp, cyc_n, pixel_x, pixel_y);
      end
   endtask

   function automatic int target_line(int y);
      return (y == 524) ? 0 : y + 1;
   endfunction

   function automatic bit is_slot(int x, int y, bit pt);
      if (!pt) return 1'b0;
      return ((x % 16 == 13) && (x <= 621) && (y < 480)) || ((x == 797) && (target_line(y) < 480));
   endfunction

   function automatic int vid_addr(int x, int y);
      if (x == 797) return (target_line(y) / 16) * COLS;
      return (y / 16) * COLS + x / 16 + 1;
   endfunction

   function automatic bit gate_ok(int y);
`ifdef TILE_VRAM_VBLANK_LOCK_EN
      return (y >= 480) && (y <= 523);
`else
      return (y >= 0);
`endif
   endfunction

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      if (p_tick) begin
         if (pixel_x == 10'd799) begin
            pixel_x = 10'd0;
            pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
         end else begin
            pixel_x = pixel_x + 10'd1;
         end
      end
      p_tick = ~p_tick;
   endtask

   task automatic jump(input int x, input int y, input bit pt);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      p_tick  = pt;
   endtask

   // One clock: predict the owner of this cycle, advance, then check the registered results.
   task automatic cyc();
      int          x;
      int          y;
      bit          s;
      bit          go;
      bit          inr;
      bit          exp_ack;
      bit          exp_we;
      logic [DW-1:0] exp_rd;
      x   = int'(pixel_x);
      y   = int'(pixel_y);
      s   = is_slot(x, y, p_tick);
      go  = h_pend && !h_acc && !s && gate_ok(y) && !KEY[0];
      inr = h_addr_m < NT;
      if (go) begin
         h_acc     = 1'b1;
         h_acc_cyc = cyc_n;
      end
      tick();
      cyc_n++;
      exp_we = go && inr && h_we_m;
      if (s) exp_addr = AW'(vid_addr(x, y));
      else if (go && inr) exp_addr = AW'(h_addr_m);
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_we", ram_we, exp_we);
      if (exp_we) chk("ram_wdata", ram_wdata, h_data_m);
      exp_ack = h_pend && h_acc && (cyc_n == h_acc_cyc + (h_we_m ? 1 : 2));
      exp_rd  = '0;
      if (exp_ack && !h_we_m && inr) exp_rd = ref_mem[h_addr_m];
      chk("host_ack", host_ack, exp_ack);
      chk("host_rdata", host_rdata, exp_rd);
      if (exp_ack) begin
         if (h_we_m && inr) ref_mem[h_addr_m] = h_data_m;
         h_done = 1'b1;
      end
      if (tile_chk && pixel_x < 10'd640 && pixel_y < 10'd480)
         chk("tile_code", tile_code, ref_mem[(int'(pixel_y) / 16) * COLS + int'(pixel_x) / 16]);
   endtask

   task automatic host_start(input bit we, input int addr, input logic [DW-1:0] d);
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = AW'(addr);
      host_wdata = d;
      h_pend     = 1'b1;
      h_acc      = 1'b0;
      h_done     = 1'b0;
      h_we_m     = we;
      h_addr_m   = addr;
      h_data_m   = d;
   endtask

   task automatic host_wait(input int bound);
      int n;
      n = 0;
      while (!h_done && n < bound) begin
         cyc();
         n++;
      end
      chk("host_done", h_done, 1);
      host_req = 1'b0;
      h_pend   = 1'b0;
      cyc();
   endtask

   task automatic run_line(input int y);
      int guard;
      guard    = 0;
      tile_chk = 1'b0;
      jump(780, (y == 0) ? 524 : y - 1, 1'b0);
      while (!(pixel_x == 10'd0 && pixel_y == 10'(y)) && guard < 100) begin
         cyc();
         guard++;
      end
      tile_chk = 1'b1;
      while (pixel_x < 10'd640 && guard < 1500) begin
         cyc();
         guard++;
      end
      tile_chk = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_wdata"}, ram_wdata, 0);
      chk({tag, "_host_ack"}, host_ack, 0);
      chk({tag, "_host_rdata"}, host_rdata, 0);
      chk({tag, "_tile_code"}, tile_code, 0);
   endtask

   initial begin
      for (int i = 0; i < NT; i++) ref_mem[i] = DW'(i % 16);
      KEY        = 4'b0001;
      p_tick     = 1'b0;
      pixel_x    = '0;
      pixel_y    = '0;
      host_req   = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      n_tests    = 0;
      n_fail     = 0;
      cyc_n      = 0;
      tile_chk   = 1'b0;
      exp_addr   = '0;
      h_pend     = 1'b0;
      h_acc      = 1'b0;
      h_done     = 1'b0;
      h_acc_cyc  = 0;
      h_we_m     = 1'b0;
      h_addr_m   = 0;
      h_data_m   = '0;

      repeat (3) @(posedge CLOCK_50);
      #1;
      check_zero("reset");
      KEY[0]   = 1'b0;
      tile_chk = 1'b1;
      repeat (28) cyc();
      chk("first_fetch_addr", ram_addr, 1);
      while (pixel_x < 10'd640) cyc();
      tile_chk = 1'b0;

      // Wrap from line 524 to line 0, then an ordinary row.
      run_line(0);
      run_line(17);
      // Line 479 ends the visible frame: no prefetch for line 480.
      jump(780, 479, 1'b0);
      repeat (60) cyc();

      // Write issued on a slot cycle, then shown on row 1, column 1.
      jump(29, HY, 1'b1);
      host_start(1'b1, 41, 4'hA);
      host_wait(64);
      run_line(16);

      jump(100, HY, 1'b0);
      host_start(1'b0, 1199, 4'h0);
      host_wait(64);
      host_start(1'b0, 1200, 4'h0);
      host_wait(64);
      host_start(1'b1, 1250, 4'h5);
      host_wait(64);

`ifdef TILE_VRAM_VBLANK_LOCK_EN
      jump(100, 100, 1'b0);
      host_start(1'b1, 7, 4'h3);
      repeat (40) cyc();
      jump(790, 479, 1'b0);
      host_wait(64);
`endif

      repeat (40) begin
`ifdef TILE_VRAM_VBLANK_LOCK_EN
         jump(int'($urandom % 800), 480 + int'($urandom % 40), 1'($urandom));
`else
         jump(int'($urandom % 800), int'($urandom % 525), 1'($urandom));
`endif
         host_start(1'($urandom), int'($urandom % 1300), DW'($urandom));
         host_wait(64);
      end
      repeat (3) run_line(int'($urandom % 480));
      run_line(0);

      // Reset while a read is between its decision and its ack.
      jump(100, HY, 1'b0);
      host_start(1'b0, 5, 4'h0);
      cyc();
      KEY[0] = 1'b1;
      #1;
      check_zero("rst_mid");
      host_req = 1'b0;
      h_pend   = 1'b0;
      tick();
      check_zero("rst_hold");
      KEY[0]   = 1'b0;
      exp_addr = '0;
      repeat (6) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
